// File: rtl/decode_pkg.sv
// RV32I decode definitions: opcodes, control-op encodings, decoded bundle and decode function.
// DECODE_RV32M_EN: when defined, OP with funct7 0000001 (MUL/DIV) decodes instead of faulting.
package decode_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] ALU_OP_NONE   = 3'd0;
    localparam logic [2:0] ALU_OP_LINK   = 3'd1;
    localparam logic [2:0] ALU_OP_IMM    = 3'd5;
    localparam logic [2:0] ALU_OP_REG    = 3'd6;
    localparam logic [2:0] ALU_OP_MULDIV = 3'd7;

    localparam logic [1:0] ADDR_OP_NONE = 2'd0;
    localparam logic [1:0] ADDR_OP_PC   = 2'd1;
    localparam logic [1:0] ADDR_OP_MEM  = 2'd2;
    localparam logic [1:0] ADDR_OP_JALR = 2'd3;

    localparam logic [1:0] WB_OP_NONE   = 2'd0;
    localparam logic [1:0] WB_OP_RESULT = 2'd1;
    localparam logic [1:0] WB_OP_ADDR   = 2'd2;

    localparam logic [1:0] JMP_OP_NONE   = 2'd0;
    localparam logic [1:0] JMP_OP_UNCOND = 2'd1;
    localparam logic [1:0] JMP_OP_BRANCH = 2'd2;

    localparam logic [1:0] MEM_OP_NONE  = 2'd0;
    localparam logic [1:0] MEM_OP_LOAD  = 2'd1;
    localparam logic [1:0] MEM_OP_STORE = 2'd2;

    typedef struct packed {
        logic               fault;
        logic [2:0]         funct3;
        logic [4:0]         rd;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic signed [31:0] imm;
        logic [2:0]         alu_op;
        logic [1:0]         addr_op;
        logic [1:0]         wb_op;
        logic [1:0]         jmp_op;
        logic [1:0]         mem_op;
    } decoded_t;

    function automatic decoded_t decode_inst(input logic [31:0] inst);
        decoded_t d;
        d         = '0;
        d.funct3  = inst[14:12];
        d.rd      = inst[11:7];
        d.rs1     = inst[19:15];
        d.rs2     = inst[24:20];
        d.alu_op  = ALU_OP_NONE;
        d.addr_op = ADDR_OP_NONE;
        d.wb_op   = WB_OP_NONE;
        d.jmp_op  = JMP_OP_NONE;
        d.mem_op  = MEM_OP_NONE;
        d.fault   = (inst[1:0] != 2'b11) || (inst == 32'd0);

        case (inst[6:0])
            OPC_LUI: begin
                d.imm   = {inst[31:12], 12'b0};
                d.wb_op = WB_OP_RESULT;
            end
            OPC_AUIPC: begin
                d.imm     = {inst[31:12], 12'b0};
                d.addr_op = ADDR_OP_PC;
                d.wb_op   = WB_OP_ADDR;
            end
            OPC_JAL: begin
                d.imm     = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
                d.alu_op  = ALU_OP_LINK;
                d.addr_op = ADDR_OP_PC;
                d.wb_op   = WB_OP_RESULT;
                d.jmp_op  = JMP_OP_UNCOND;
            end
            OPC_JALR: begin
                d.imm     = {{20{inst[31]}}, inst[31:20]};
                d.alu_op  = ALU_OP_LINK;
                d.addr_op = ADDR_OP_JALR;
                d.wb_op   = WB_OP_RESULT;
                d.jmp_op  = JMP_OP_UNCOND;
            end
            OPC_BRANCH: begin
                d.imm     = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
                d.addr_op = ADDR_OP_PC;
                d.jmp_op  = JMP_OP_BRANCH;
            end
            OPC_LOAD: begin
                d.imm     = {{20{inst[31]}}, inst[31:20]};
                d.addr_op = ADDR_OP_MEM;
                d.wb_op   = WB_OP_RESULT;
                d.mem_op  = MEM_OP_LOAD;
            end
            OPC_STORE: begin
                d.imm     = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                d.addr_op = ADDR_OP_MEM;
                d.mem_op  = MEM_OP_STORE;
            end
            OPC_OP_IMM: begin
                d.imm    = {{20{inst[31]}}, inst[31:20]};
                d.alu_op = ALU_OP_IMM;
                d.wb_op  = WB_OP_RESULT;
            end
            OPC_OP: begin
                if (inst[31:25] == FUNCT7_MULDIV) begin
`ifdef DECODE_RV32M_EN
                    d.alu_op = ALU_OP_MULDIV;
                    d.wb_op  = WB_OP_RESULT;
`else
                    d.fault  = 1'b1;
`endif
                end else begin
                    d.alu_op = ALU_OP_REG;
                    d.wb_op  = WB_OP_RESULT;
                end
            end
            default: d.fault = 1'b1;
        endcase

        // A faulted entry keeps its register fields but must never trigger execute-side work.
        if (d.fault) begin
            d.imm     = '0;
            d.alu_op  = ALU_OP_NONE;
            d.addr_op = ADDR_OP_NONE;
            d.wb_op   = WB_OP_NONE;
            d.jmp_op  = JMP_OP_NONE;
            d.mem_op  = MEM_OP_NONE;
        end
        return d;
    endfunction

endpackage

// File: rtl/inst_fifo.sv
// Circular FIFO of {pc, inst} entries with occupancy count; flush empties it in one cycle.
module inst_fifo import decode_pkg::*; #(
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             i_wr_en,
    input  logic [63:0]      i_wr_data,
    input  logic             i_rd_en,
    output logic [63:0]      o_rd_data,
    output logic [PTR_W:0]   o_count,
    output logic             o_full,
    output logic             o_empty
);

    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [63:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_full    = (r_count == CNT_FULL);
    assign o_empty   = (r_count == '0);
    assign w_wr      = i_wr_en & ~o_full;
    assign w_rd      = i_rd_en & ~o_empty;
    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
    end

endmodule

// File: rtl/decode_queue.sv
// Buffered valid/ready RV32I decode stage: FIFO plus a registered decoded output slot with bypass.
// DECODE_RV32M_EN (see decode_pkg) enables MUL/DIV decode.
module decode_queue import decode_pkg::*; #(
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [31:0]      in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic             out_fault,
    output logic [2:0]       funct3,
    output logic [4:0]       rd,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [31:0]      imm,
    output logic [2:0]       alu_op,
    output logic [1:0]       addr_alu_op,
    output logic [1:0]       wb_op,
    output logic [1:0]       jmp_op,
    output logic [1:0]       mem_op,
    output logic [PTR_W:0]   count
);

    logic        w_in_fire;
    logic        w_out_fire;
    logic        w_slot_load;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic        w_bypass;
    logic        w_fifo_wr;
    logic        w_fifo_rd;
    logic [63:0] w_fifo_head;
    logic [31:0] w_src_pc;
    logic [31:0] w_src_inst;
    decoded_t    w_src_dec;

    logic        r_vld_p1;
    logic [31:0] r_pc_p1;
    decoded_t    r_dec_p1;

    assign in_ready    = ~w_fifo_full;
    assign w_in_fire   = in_valid & in_ready;
    assign w_out_fire  = r_vld_p1 & out_ready;
    assign w_slot_load = ~r_vld_p1 | w_out_fire;

    // With nothing buffered the slot takes the incoming instruction directly, skipping the FIFO.
    assign w_bypass  = w_slot_load & w_fifo_empty;
    assign w_fifo_wr = w_in_fire & ~w_bypass & ~flush;
    assign w_fifo_rd = w_slot_load & ~w_fifo_empty & ~flush;

    assign w_src_pc   = w_fifo_empty ? in_pc   : w_fifo_head[63:32];
    assign w_src_inst = w_fifo_empty ? in_inst : w_fifo_head[31:0];
    assign w_src_dec  = decode_inst(w_src_inst);

    inst_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .i_wr_en   (w_fifo_wr),
        .i_wr_data ({in_pc, in_inst}),
        .i_rd_en   (w_fifo_rd),
        .o_rd_data (w_fifo_head),
        .o_count   (count),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty)
    );

    // Output slot stage (p1)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
            r_pc_p1  <= '0;
            r_dec_p1 <= '0;
        end else if (flush) begin
            r_vld_p1 <= 1'b0;
        end else if (w_slot_load) begin
            if (!w_fifo_empty || w_in_fire) begin
                r_vld_p1 <= 1'b1;
                r_pc_p1  <= w_src_pc;
                r_dec_p1 <= w_src_dec;
            end else begin
                r_vld_p1 <= 1'b0;
            end
        end
    end

    assign out_valid   = r_vld_p1;
    assign out_pc      = r_pc_p1;
    assign out_fault   = r_dec_p1.fault;
    assign funct3      = r_dec_p1.funct3;
    assign rd          = r_dec_p1.rd;
    assign rs1         = r_dec_p1.rs1;
    assign rs2         = r_dec_p1.rs2;
    assign imm         = r_dec_p1.imm;
    assign alu_op      = r_dec_p1.alu_op;
    assign addr_alu_op = r_dec_p1.addr_op;
    assign wb_op       = r_dec_p1.wb_op;
    assign jmp_op      = r_dec_p1.jmp_op;
    assign mem_op      = r_dec_p1.mem_op;

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: reset, bypass latency, backpressure, streaming, faults, flush, RV32M.
module tb_decode_queue;

    localparam int DEPTH = 4;
    localparam int PTR_W = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_inst;
    logic [31:0]      in_pc;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_pc;
    logic             out_fault;
    logic [2:0]       funct3;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [31:0]      imm;
    logic [2:0]       alu_op;
    logic [1:0]       addr_alu_op;
    logic [1:0]       wb_op;
    logic [1:0]       jmp_op;
    logic [1:0]       mem_op;
    logic [PTR_W:0]   count;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] tbl_inst [4];
    logic [31:0] tbl_imm  [4];
    logic [2:0]  tbl_alu  [4];
    logic [1:0]  tbl_addr [4];
    logic [1:0]  tbl_wb   [4];
    logic [1:0]  tbl_jmp  [4];
    logic [1:0]  tbl_mem  [4];

    decode_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_inst     (in_inst),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_fault   (out_fault),
        .funct3      (funct3),
        .rd          (rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .imm         (imm),
        .alu_op      (alu_op),
        .addr_alu_op (addr_alu_op),
        .wb_op       (wb_op),
        .jmp_op      (jmp_op),
        .mem_op      (mem_op),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // addi rd, x0, 0 : used as an order-tagging payload (rd carries the sequence number)
    function automatic logic [31:0] addi_rd(input int r);
        return 32'h0000_0013 | (32'(r) << 7);
    endfunction

    initial begin
        tbl_inst[0] = 32'h0080A283; tbl_imm[0] = 32'd8;        tbl_alu[0] = 3'd0; tbl_addr[0] = 2'd2; tbl_wb[0] = 2'd1; tbl_jmp[0] = 2'd0; tbl_mem[0] = 2'd1;
        tbl_inst[1] = 32'h0050A623; tbl_imm[1] = 32'd12;       tbl_alu[1] = 3'd0; tbl_addr[1] = 2'd2; tbl_wb[1] = 2'd0; tbl_jmp[1] = 2'd0; tbl_mem[1] = 2'd2;
        tbl_inst[2] = 32'h010000EF; tbl_imm[2] = 32'd16;       tbl_alu[2] = 3'd1; tbl_addr[2] = 2'd1; tbl_wb[2] = 2'd1; tbl_jmp[2] = 2'd1; tbl_mem[2] = 2'd0;
        tbl_inst[3] = 32'h123453B7; tbl_imm[3] = 32'h12345000; tbl_alu[3] = 3'd0; tbl_addr[3] = 2'd0; tbl_wb[3] = 2'd1; tbl_jmp[3] = 2'd0; tbl_mem[3] = 2'd0;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = 32'd0; in_pc = 32'd0;
        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_pc",    out_pc,         32'd0);
        chk("rst_fault",     32'(out_fault), 32'd0);
        chk("rst_imm",       imm,            32'd0);
        chk("rst_alu",       32'(alu_op),    32'd0);
        chk("rst_rd",        32'(rd),        32'd0);
        rst = 1'b0;

        // addi x3,x2,1 through the bypass path
        in_valid = 1'b1; in_inst = 32'h00110193; in_pc = 32'h100; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_rd",    32'(rd),        32'd3);
        chk("t1_rs1",   32'(rs1),       32'd2);
        chk("t1_imm",   imm,            32'd1);
        chk("t1_alu",   32'(alu_op),    32'd5);
        chk("t1_wb",    32'(wb_op),     32'd1);
        chk("t1_pc",    out_pc,         32'h100);
        chk("t1_count", 32'(count),     32'd0);
        chk("t1_fault", 32'(out_fault), 32'd0);
        step();
        chk("t1_drained", 32'(out_valid), 32'd0);

        // Backpressure: slot plus full FIFO, then drain with a late push
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_inst = addi_rd(i + 1); in_pc = 32'h200 + 32'(4 * i);
            step();
        end
        chk("bp_count_full", 32'(count),    32'd4);
        chk("bp_slot_pc",    out_pc,        32'h200);
        chk("bp_slot_hold",  32'(rd),       32'd1);
        in_valid = 1'b1; in_inst = addi_rd(6); in_pc = 32'h214;
        chk("bp_in_ready_full", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        chk("bp_in_ready_pop", 32'(in_ready), 32'd0);
        step();
        chk("bp_pc1",       out_pc,        32'h204);
        chk("bp_count1",    32'(count),    32'd3);
        chk("bp_in_ready1", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("bp_pc2",    out_pc,     32'h208);
        chk("bp_count2", 32'(count), 32'd3);
        for (int k = 3; k < 6; k++) begin
            step();
            chk("bp_pc",    out_pc,     32'h200 + 32'(4 * k));
            chk("bp_rd",    32'(rd),    32'(k + 1));
            chk("bp_count", 32'(count), 32'(5 - k));
        end
        step();
        chk("bp_empty", 32'(out_valid), 32'd0);

        // Steady streaming with two entries buffered
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_inst = addi_rd(i + 1); in_pc = 32'h400 + 32'(4 * i);
            step();
        end
        out_ready = 1'b1;
        for (int j = 0; j < 10; j++) begin
            in_valid = 1'b1; in_inst = addi_rd(j + 4); in_pc = 32'h400 + 32'(4 * (j + 3));
            chk("st_pc",    out_pc,         32'h400 + 32'(4 * j));
            chk("st_rd",    32'(rd),        32'(j + 1));
            chk("st_count", 32'(count),     32'd2);
            chk("st_valid", 32'(out_valid), 32'd1);
            step();
        end
        in_valid = 1'b0;
        for (int j = 10; j < 13; j++) begin
            chk("st_tail_pc",    out_pc,     32'h400 + 32'(4 * j));
            chk("st_tail_count", 32'(count), 32'(12 - j));
            step();
        end
        chk("st_empty", 32'(out_valid), 32'd0);

        // Faults: all-zero word, bad low bits, then a valid backward branch
        in_valid = 1'b1; in_inst = 32'h0000_0000; in_pc = 32'h500;
        step();
        in_inst = 32'h00110190; in_pc = 32'h504;
        chk("f0_valid", 32'(out_valid),   32'd1);
        chk("f0_fault", 32'(out_fault),   32'd1);
        chk("f0_alu",   32'(alu_op),      32'd0);
        chk("f0_wb",    32'(wb_op),       32'd0);
        chk("f0_addr",  32'(addr_alu_op), 32'd0);
        chk("f0_pc",    out_pc,           32'h500);
        step();
        in_inst = 32'hFE209EE3; in_pc = 32'h508;
        chk("f1_fault", 32'(out_fault), 32'd1);
        chk("f1_rd",    32'(rd),        32'd3);
        chk("f1_rs1",   32'(rs1),       32'd2);
        chk("f1_alu",   32'(alu_op),    32'd0);
        chk("f1_wb",    32'(wb_op),     32'd0);
        step();
        in_valid = 1'b0;
        chk("bne_fault",  32'(out_fault),   32'd0);
        chk("bne_jmp",    32'(jmp_op),      32'd2);
        chk("bne_addr",   32'(addr_alu_op), 32'd1);
        chk("bne_imm",    imm,              32'hFFFFFFFC);
        chk("bne_rs1",    32'(rs1),         32'd1);
        chk("bne_rs2",    32'(rs2),         32'd2);
        chk("bne_funct3", 32'(funct3),      32'd1);
        chk("bne_wb",     32'(wb_op),       32'd0);
        chk("bne_pc",     out_pc,           32'h508);
        step();

        // Load / store / jal / lui encodings
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_inst = tbl_inst[i]; in_pc = 32'h900 + 32'(4 * i);
            step();
            chk("enc_fault", 32'(out_fault),   32'd0);
            chk("enc_imm",   imm,              tbl_imm[i]);
            chk("enc_alu",   32'(alu_op),      32'(tbl_alu[i]));
            chk("enc_addr",  32'(addr_alu_op), 32'(tbl_addr[i]));
            chk("enc_wb",    32'(wb_op),       32'(tbl_wb[i]));
            chk("enc_jmp",   32'(jmp_op),      32'(tbl_jmp[i]));
            chk("enc_mem",   32'(mem_op),      32'(tbl_mem[i]));
        end
        in_valid = 1'b0;
        step();

        // Flush with a same-cycle offer
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_inst = addi_rd(i + 1); in_pc = 32'h600 + 32'(4 * i);
            step();
        end
        chk("fl_pre_count", 32'(count), 32'd2);
        in_valid = 1'b1; in_inst = addi_rd(9); in_pc = 32'h6F0; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_valid",    32'(out_valid), 32'd0);
        chk("fl_count",    32'(count),     32'd0);
        chk("fl_in_ready", 32'(in_ready),  32'd1);
        out_ready = 1'b1;
        in_valid = 1'b1; in_inst = addi_rd(10); in_pc = 32'h700;
        step();
        in_valid = 1'b0;
        chk("fl_next_valid", 32'(out_valid), 32'd1);
        chk("fl_next_pc",    out_pc,         32'h700);
        chk("fl_next_rd",    32'(rd),        32'd10);
        chk("fl_next_count", 32'(count),     32'd0);
        step();
        chk("fl_after_valid", 32'(out_valid), 32'd0);

        // mul x1,x2,x3
        in_valid = 1'b1; in_inst = 32'h023100B3; in_pc = 32'h800;
        step();
        in_valid = 1'b0;
        chk("mul_rd",     32'(rd),     32'd1);
        chk("mul_funct3", 32'(funct3), 32'd0);
`ifdef DECODE_RV32M_EN
        chk("mul_fault", 32'(out_fault), 32'd0);
        chk("mul_alu",   32'(alu_op),    32'd7);
        chk("mul_wb",    32'(wb_op),     32'd1);
`else
        chk("mul_fault", 32'(out_fault), 32'd1);
        chk("mul_alu",   32'(alu_op),    32'd0);
        chk("mul_wb",    32'(wb_op),     32'd0);
`endif
        step();

        // Reset wins over flush while holding entries
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_inst = addi_rd(i + 1); in_pc = 32'hA00 + 32'(4 * i);
            step();
        end
        in_valid = 1'b0; rst = 1'b1; flush = 1'b1;
        step();
        rst = 1'b0; flush = 1'b0;
        chk("rr_valid", 32'(out_valid), 32'd0);
        chk("rr_count", 32'(count),     32'd0);
        chk("rr_pc",    out_pc,         32'd0);
        chk("rr_rd",    32'(rd),        32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
